// File: rtl/conv2d_ker_scheduler_pkg.sv
// Shared conv2d definitions: kernel scheduler state encoding,
// channel field width and kernel BRAM controller timing.
package conv2d_ker_scheduler_pkg;

  localparam int CH_W = 9;

  // BRAM controller needs this many cycles after a read-address update
  localparam int KB_SETTLE = 3;

  localparam logic [3:0] ST_IDLE      = 4'd0;
  localparam logic [3:0] ST_LOAD      = 4'd1;
  localparam logic [3:0] ST_WAIT_LOAD = 4'd2;
  localparam logic [3:0] ST_COMPUTE   = 4'd3;
  localparam logic [3:0] ST_WAIT_CH   = 4'd4;
  localparam logic [3:0] ST_ADVANCE   = 4'd5;
  localparam logic [3:0] ST_SETTLE    = 4'd6;
  localparam logic [3:0] ST_NEXT_OCH  = 4'd7;
  localparam logic [3:0] ST_FINISH    = 4'd8;

  typedef enum logic [3:0] {
    IDLE      = ST_IDLE,
    LOAD      = ST_LOAD,
    WAIT_LOAD = ST_WAIT_LOAD,
    COMPUTE   = ST_COMPUTE,
    WAIT_CH   = ST_WAIT_CH,
    ADVANCE   = ST_ADVANCE,
    SETTLE    = ST_SETTLE,
    NEXT_OCH  = ST_NEXT_OCH,
    FINISH    = ST_FINISH
  } state_e;

endpackage

// File: rtl/conv2d_ker_scheduler_if.sv
// Kernel scheduler control bundle: sequence control, kernel BRAM
// commands/flags and datapath channel handshake.
interface conv2d_ker_scheduler_if #(
  parameter int CH_W = conv2d_ker_scheduler_pkg::CH_W
);
  logic            start;
  logic            abort;
  logic [CH_W-1:0] CHANNEL_SIZE;
  logic [CH_W-1:0] OUT_CHANNELS;
  logic            load_BRAM_dina;
  logic            update_BRAM_doutb;
  logic            done_loading_1ker;
  logic            last_channel;
  logic            ch_start;
  logic            ch_done;
  logic            och_done;
  logic [CH_W-1:0] och_index;
  logic            busy;
  logic            done;
  logic            err;

  modport master (
    input  start, abort, CHANNEL_SIZE, OUT_CHANNELS,
    input  done_loading_1ker, last_channel, ch_done,
    output load_BRAM_dina, update_BRAM_doutb, ch_start,
    output och_done, och_index, busy, done, err
  );

  modport slave (
    output start, abort, CHANNEL_SIZE, OUT_CHANNELS,
    output done_loading_1ker, last_channel, ch_done,
    input  load_BRAM_dina, update_BRAM_doutb, ch_start,
    input  och_done, och_index, busy, done, err
  );
endinterface

// File: rtl/conv2d_ker_scheduler_wdt.sv
// Wait-state watchdog for the kernel scheduler.
// Present only when KER_SCHED_TIMEOUT_EN is defined.
`ifdef KER_SCHED_TIMEOUT_EN
module ker_sched_wdt #(
  parameter int W = 16
) (
  input  logic clk,
  input  logic Reset,
  input  logic en,
  output logic expire
);
  logic [W-1:0] cnt;
  logic [W-1:0] cnt_n;

  assign cnt_n  = cnt + 1'b1;
  // fires on the cycle whose increment would reach all-ones
  assign expire = en && (&cnt_n);

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset)           cnt <= '0;
    else if (!en || expire) cnt <= '0;
    else                  cnt <= cnt_n;
  end
endmodule
`endif

// File: rtl/conv2d_ker_scheduler.sv
// Conv2d kernel scheduler: sequences kernel loads and per-channel compute.
// Optional wait-state watchdog: KER_SCHED_TIMEOUT_EN.
module conv2d_ker_scheduler #(
  parameter int CH_W  = conv2d_ker_scheduler_pkg::CH_W,
  parameter int WDT_W = 16
) (
  input logic clk,
  input logic Reset,
  conv2d_ker_scheduler_if.master bus
);
  import conv2d_ker_scheduler_pkg::*;

  state_e state, state_n;

  logic [CH_W-1:0] ch_size, out_ch;
  logic [CH_W-1:0] ic, och;
  logic [1:0]      settle;

  logic load_q, upd_q, chs_q, ochd_q;
  logic busy_q, done_q, err_q;

  logic ic_last, och_last, cfg_zero;
  logic wdt_exp, kill;

  assign ic_last  = (ic == ch_size);
  assign och_last = (och == out_ch - 1'b1);
  assign cfg_zero = (bus.CHANNEL_SIZE == '0) ||
                    (bus.OUT_CHANNELS == '0);

`ifdef KER_SCHED_TIMEOUT_EN
  ker_sched_wdt #(.W(WDT_W)) u_wdt (
    .clk    (clk),
    .Reset  (Reset),
    .en     ((state == WAIT_LOAD) || (state == WAIT_CH)),
    .expire (wdt_exp)
  );
`else
  assign wdt_exp = 1'b0;
`endif

  assign kill = (state != IDLE) && (state != FINISH) &&
                (bus.abort || wdt_exp);

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:
        if (bus.start) state_n = cfg_zero ? FINISH : LOAD;
      LOAD:      state_n = WAIT_LOAD;
      WAIT_LOAD: if (bus.done_loading_1ker) state_n = COMPUTE;
      COMPUTE:   state_n = WAIT_CH;
      WAIT_CH:   if (bus.ch_done) state_n = ADVANCE;
      ADVANCE:   state_n = SETTLE;
      SETTLE:
        if (settle == 2'(KB_SETTLE - 1))
          state_n = ic_last ? NEXT_OCH : COMPUTE;
      NEXT_OCH:  state_n = och_last ? FINISH : LOAD;
      FINISH:    state_n = IDLE;
      default:   state_n = IDLE;
    endcase
    if (kill) state_n = FINISH;
  end

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) state <= IDLE;
    else        state <= state_n;
  end

  // command pulses trail their state by one cycle; abort suppresses them
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      load_q <= 1'b0;
      upd_q  <= 1'b0;
      chs_q  <= 1'b0;
      ochd_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      load_q <= (state == LOAD)     && !kill;
      upd_q  <= (state == ADVANCE)  && !kill;
      chs_q  <= (state == COMPUTE)  && !kill;
      ochd_q <= (state == NEXT_OCH) && !kill;
      busy_q <= (state_n != IDLE);
      done_q <= (state == FINISH);
    end
  end

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      ch_size <= '0;
      out_ch  <= '0;
      ic      <= '0;
      och     <= '0;
      settle  <= '0;
      err_q   <= 1'b0;
    end else begin
      if ((state == SETTLE) && (state_n == SETTLE))
        settle <= settle + 1'b1;
      else
        settle <= '0;

      if ((state == IDLE) && bus.start) begin
        ch_size <= bus.CHANNEL_SIZE;
        out_ch  <= bus.OUT_CHANNELS;
        ic      <= '0;
        och     <= '0;
        err_q   <= 1'b0;
      end

      if ((state == ADVANCE) && !kill)
        ic <= ic + 1'b1;

      // controller flag cross-check; ic stays authoritative
      if ((state == SETTLE) && (settle == 2'd1) &&
          (bus.last_channel != ic_last))
        err_q <= 1'b1;

      if (state == NEXT_OCH) begin
        ic <= '0;
        if (!och_last && !kill) och <= och + 1'b1;
      end

      if (wdt_exp) err_q <= 1'b1;
    end
  end

  assign bus.load_BRAM_dina    = load_q;
  assign bus.update_BRAM_doutb = upd_q;
  assign bus.ch_start          = chs_q;
  assign bus.och_done          = ochd_q;
  assign bus.och_index         = och;
  assign bus.busy              = busy_q;
  assign bus.done              = done_q;
  assign bus.err               = err_q;

endmodule
